// File: rtl/datapath.sv
// Processor datapath: 256x16 data memory, 16-bit PC, 8x16 register file,
// add/sub/LHI/LLI ALU with NZVC flags, and a registered output port.
module datapath (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_wen,
    input  logic        mem_ren,
    input  logic [7:0]  mem_addr,
    input  logic [15:0] mem_datain,
    output logic [15:0] mem_dataout,
    input  logic        pc_en,
    input  logic        pc_inc0_jum1,
    input  logic [15:0] pc_ext,
    output logic [15:0] pc_addr,
    input  logic        rf_en,
    input  logic [2:0]  rf_addr,
    input  logic [1:0]  rf_op,
    input  logic [2:0]  rf_readA,
    input  logic [2:0]  rf_readB,
    output logic [15:0] rf_B,
    input  logic        add0_sub1,
    input  logic        LHI,
    input  logic        LLI,
    input  logic        ext_imm,
    input  logic [15:0] ext_immB,
    output logic [15:0] alu_out,
    output logic        N,
    output logic        Z,
    output logic        V,
    output logic        C,
    input  logic        ctro_outR,
    output logic [15:0] OutR
);

    logic [15:0] mem [0:255];
    logic [15:0] rf  [0:7];
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [15:0] b_eff;
    logic [16:0] sum;
    logic [15:0] rf_wdata;

    assign op_a = rf[rf_readA];
    assign rf_B = rf[rf_readB];
    assign op_b = ext_imm ? ext_immB : rf_B;

    // Subtraction is A + ~B + 1, so C reads as "no borrow" for sub.
    always_comb begin
        b_eff   = add0_sub1 ? ~op_b : op_b;
        sum     = {1'b0, op_a} + {1'b0, b_eff} + 17'(add0_sub1);
        alu_out = sum[15:0];
        C       = sum[16];
        V       = (op_a[15] == b_eff[15]) && (sum[15] != op_a[15]);
        if (LHI) begin
            alu_out = {op_b[7:0], op_a[7:0]};
            C       = 1'b0;
            V       = 1'b0;
        end else if (LLI) begin
            alu_out = {op_a[15:8], op_b[7:0]};
            C       = 1'b0;
            V       = 1'b0;
        end
    end

    assign N = alu_out[15];
    assign Z = (alu_out == 16'h0000);

    always_comb begin
        rf_wdata = alu_out;
        case (rf_op)
            2'd0:    rf_wdata = alu_out;
            2'd1:    rf_wdata = mem_dataout;
            2'd2:    rf_wdata = pc_addr;
            default: rf_wdata = ext_immB;
        endcase
    end

    // The array itself is never cleared; reset only blocks writes into it.
    always_ff @(posedge clk) begin
        if (!rst && mem_wen)
            mem[mem_addr] <= mem_datain;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mem_dataout <= 16'h0000;
        else if (mem_ren)
            mem_dataout <= mem[mem_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc_addr <= 16'h0000;
        else if (pc_en)
            pc_addr <= pc_inc0_jum1 ? pc_ext : pc_addr + 16'h0001;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++)
                rf[i] <= 16'h0000;
        end else if (rf_en) begin
            rf[rf_addr] <= rf_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            OutR <= 16'h0000;
        else if (ctro_outR)
            OutR <= op_a;
    end

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed scenarios plus randomized
// traffic compared against an arithmetic reference model.
module tb_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_wen, mem_ren;
    logic [7:0]  mem_addr;
    logic [15:0] mem_datain, mem_dataout;
    logic        pc_en, pc_inc0_jum1;
    logic [15:0] pc_ext, pc_addr;
    logic        rf_en;
    logic [2:0]  rf_addr;
    logic [1:0]  rf_op;
    logic [2:0]  rf_readA, rf_readB;
    logic [15:0] rf_B;
    logic        add0_sub1, LHI, LLI, ext_imm;
    logic [15:0] ext_immB, alu_out;
    logic        N, Z, V, C;
    logic        ctro_outR;
    logic [15:0] OutR;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem_m [256];
    logic [15:0] rf_m  [8];
    logic [15:0] pc_m, outr_m, mdo_m;

    datapath dut (
        .clk(clk), .rst(rst),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr),
        .mem_datain(mem_datain), .mem_dataout(mem_dataout),
        .pc_en(pc_en), .pc_inc0_jum1(pc_inc0_jum1), .pc_ext(pc_ext), .pc_addr(pc_addr),
        .rf_en(rf_en), .rf_addr(rf_addr), .rf_op(rf_op),
        .rf_readA(rf_readA), .rf_readB(rf_readB), .rf_B(rf_B),
        .add0_sub1(add0_sub1), .LHI(LHI), .LLI(LLI), .ext_imm(ext_imm),
        .ext_immB(ext_immB), .alu_out(alu_out),
        .N(N), .Z(Z), .V(V), .C(C),
        .ctro_outR(ctro_outR), .OutR(OutR)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    // Reference ALU computed from the arithmetic definition of each operation.
    task automatic alu_ref(output logic [15:0] r, output logic n, z, v, c);
        logic [15:0] a, b;
        int ua, ub, sa, sb, full, sfull;
        a = rf_m[rf_readA];
        b = ext_imm ? ext_immB : rf_m[rf_readB];
        v = 1'b0;
        c = 1'b0;
        if (LHI) begin
            r = {b[7:0], a[7:0]};
        end else if (LLI) begin
            r = {a[15:8], b[7:0]};
        end else begin
            ua = a; ub = b;
            sa = $signed(a); sb = $signed(b);
            if (add0_sub1) begin
                full = ua - ub; sfull = sa - sb; c = (ua >= ub);
            end else begin
                full = ua + ub; sfull = sa + sb; c = (full > 65535);
            end
            r = full[15:0];
            v = (sfull > 32767) || (sfull < -32768);
        end
        n = r[15];
        z = (r == 16'h0000);
    endtask

    task automatic model_reset();
        pc_m = 0; outr_m = 0; mdo_m = 0;
        for (int i = 0; i < 8; i++) rf_m[i] = 0;
    endtask

    task automatic model_edge();
        logic [15:0] r, wd, new_pc, new_out, new_mdo;
        logic n, z, v, c;
        if (rst) return;
        alu_ref(r, n, z, v, c);
        case (rf_op)
            2'd0: wd = r;
            2'd1: wd = mdo_m;
            2'd2: wd = pc_m;
            default: wd = ext_immB;
        endcase
        new_pc  = pc_en ? (pc_inc0_jum1 ? pc_ext : 16'((32'(pc_m) + 1) % 65536)) : pc_m;
        new_out = ctro_outR ? rf_m[rf_readA] : outr_m;
        new_mdo = mem_ren ? mem_m[mem_addr] : mdo_m;
        if (mem_wen) mem_m[mem_addr] = mem_datain;
        if (rf_en) rf_m[rf_addr] = wd;
        pc_m = new_pc; outr_m = new_out; mdo_m = new_mdo;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_wen = 0; mem_ren = 0; mem_addr = 0; mem_datain = 0;
        pc_en = 0; pc_inc0_jum1 = 0; pc_ext = 0;
        rf_en = 0; rf_addr = 0; rf_op = 0; rf_readA = 0; rf_readB = 0;
        add0_sub1 = 0; LHI = 0; LLI = 0; ext_imm = 0; ext_immB = 0;
        ctro_outR = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        model_reset();
        repeat (3) tick();
        rst = 0;
        #1;
        if (pc_addr !== 16'h0000) begin errors++; $display("[TB] FAIL reset_pc got %h expected 0000", pc_addr); end
        checks++;
        if (OutR !== 16'h0000) begin errors++; $display("[TB] FAIL reset_outr got %h expected 0000", OutR); end
        checks++;
        if (mem_dataout !== 16'h0000) begin errors++; $display("[TB] FAIL reset_mdo got %h expected 0000", mem_dataout); end
        checks++;
        for (int i = 0; i < 8; i++) begin
            rf_readB = 3'(i);
            #1;
            if (rf_B !== 16'h0000) begin errors++; $display("[TB] FAIL reset_rf%0d got %h expected 0000", i, rf_B); end
            checks++;
        end
    endtask

    task automatic test_memory();
        idle();
        mem_wen = 1; mem_addr = 8'h00; mem_datain = 16'h5487;
        tick();
        if (mem_dataout !== 16'h0000) begin errors++; $display("[TB] FAIL mem_hold got %h expected 0000", mem_dataout); end
        checks++;
        mem_wen = 0; mem_ren = 1;
        tick();
        if (mem_dataout !== 16'h5487) begin errors++; $display("[TB] FAIL mem_read got %h expected 5487", mem_dataout); end
        checks++;
        idle();
    endtask

    task automatic test_back_to_back();
        idle();
        mem_wen = 1; mem_ren = 1; mem_addr = 8'h00; mem_datain = 16'hBEEF;
        tick();
        if (mem_dataout !== 16'h5487) begin errors++; $display("[TB] FAIL mem_rw_old got %h expected 5487", mem_dataout); end
        checks++;
        mem_wen = 0;
        tick();
        if (mem_dataout !== 16'hBEEF) begin errors++; $display("[TB] FAIL mem_rw_new got %h expected beef", mem_dataout); end
        checks++;
        idle();
    endtask

    task automatic test_mem_fill();
        idle();
        mem_wen = 1;
        for (int i = 0; i < 256; i++) begin
            mem_addr = 8'(i);
            mem_datain = 16'($urandom);
            tick();
        end
        idle();
    endtask

    task automatic test_regs();
        logic [15:0] exp_out [5];
        exp_out = '{16'h00FF, 16'h00FF, 16'h0012, 16'h0034, 16'h0046};
        idle();
        LLI = 1; ext_imm = 1; ext_immB = 16'h00FF; rf_readA = 0; rf_op = 0; rf_en = 1;
        rf_addr = 0; tick();
        rf_addr = 1; tick();
        rf_en = 0;
        rf_readB = 0; #1;
        if (rf_B !== 16'h00FF) begin errors++; $display("[TB] FAIL r0_lli got %h expected 00ff", rf_B); end
        checks++;
        rf_readB = 1; #1;
        if (rf_B !== 16'h00FF) begin errors++; $display("[TB] FAIL r1_lli got %h expected 00ff", rf_B); end
        checks++;
        rf_en = 1;
        ext_immB = 16'h0012; rf_addr = 2; tick();
        ext_immB = 16'h0034; rf_addr = 3; tick();
        rf_en = 0; LLI = 0; ext_imm = 0; rf_readA = 2; rf_readB = 3; add0_sub1 = 0;
        #1;
        if (alu_out !== 16'h0046) begin errors++; $display("[TB] FAIL add_46 got %h expected 0046", alu_out); end
        checks++;
        if ({N, Z, V, C} !== 4'b0000) begin errors++; $display("[TB] FAIL add_46_flags got %b expected 0000", {N, Z, V, C}); end
        checks++;
        rf_en = 1; rf_addr = 4; tick();
        rf_en = 0; ctro_outR = 1;
        for (int i = 0; i < 5; i++) begin
            rf_readA = 3'(i);
            tick();
            if (OutR !== exp_out[i]) begin errors++; $display("[TB] FAIL outr_r%0d got %h expected %h", i, OutR, exp_out[i]); end
            checks++;
        end
        idle();
    endtask

    task automatic test_flags();
        idle();
        rf_readA = 3; rf_readB = 3; add0_sub1 = 1;
        #1;
        if (alu_out !== 16'h0000 || Z !== 1'b1 || C !== 1'b1) begin
            errors++; $display("[TB] FAIL sub_zero got %h Z%b C%b expected 0000 Z1 C1", alu_out, Z, C);
        end
        checks++;
        add0_sub1 = 0; LHI = 1; ext_imm = 1; ext_immB = 16'h007F; rf_readA = 0;
        rf_en = 1; rf_addr = 5; tick();
        LHI = 0; LLI = 1; ext_immB = 16'h00CD; rf_readA = 2; rf_addr = 6; tick();
        rf_en = 0; LLI = 0; rf_readA = 5; ext_immB = 16'h0001;
        #1;
        if (alu_out !== 16'h8000 || N !== 1'b1 || V !== 1'b1 || C !== 1'b0) begin
            errors++; $display("[TB] FAIL add_ovf got %h N%b V%b C%b expected 8000 N1 V1 C0", alu_out, N, V, C);
        end
        checks++;
        LHI = 1; rf_readA = 6; ext_immB = 16'h00AB;
        #1;
        if (alu_out !== 16'hABCD || V !== 1'b0 || C !== 1'b0) begin
            errors++; $display("[TB] FAIL lhi_abcd got %h V%b C%b expected abcd V0 C0", alu_out, V, C);
        end
        checks++;
        idle();
    endtask

    task automatic test_pc();
        idle();
        pc_en = 1; pc_inc0_jum1 = 1; pc_ext = 16'hFFFF; tick();
        pc_inc0_jum1 = 0; tick();
        if (pc_addr !== 16'h0000) begin errors++; $display("[TB] FAIL pc_wrap got %h expected 0000", pc_addr); end
        checks++;
        pc_inc0_jum1 = 1; pc_ext = 16'h1234; tick();
        if (pc_addr !== 16'h1234) begin errors++; $display("[TB] FAIL pc_jump got %h expected 1234", pc_addr); end
        checks++;
        idle();
        ctro_outR = 1; rf_readA = 4; tick();
        ctro_outR = 0;
        @(posedge clk);
        #2;
        rst = 1;
        model_reset();
        #1;
        if (pc_addr !== 16'h0000 || OutR !== 16'h0000) begin
            errors++; $display("[TB] FAIL async_rst got pc %h outr %h expected 0000 0000", pc_addr, OutR);
        end
        checks++;
        @(negedge clk);
        rst = 0;
        #1;
    endtask

    task automatic test_random();
        logic [15:0] r;
        logic n, z, v, c;
        for (int k = 0; k < 400; k++) begin
            mem_wen = 1'($urandom); mem_ren = 1'($urandom);
            mem_addr = 8'($urandom); mem_datain = 16'($urandom);
            pc_en = 1'($urandom); pc_inc0_jum1 = ($urandom_range(0, 3) == 0);
            pc_ext = 16'($urandom);
            rf_en = 1'($urandom); rf_addr = 3'($urandom); rf_op = 2'($urandom);
            rf_readA = 3'($urandom); rf_readB = 3'($urandom);
            add0_sub1 = 1'($urandom); ext_imm = 1'($urandom);
            LHI = ($urandom_range(0, 7) == 0); LLI = ($urandom_range(0, 7) == 0);
            ext_immB = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
            ctro_outR = 1'($urandom);
            #1;
            alu_ref(r, n, z, v, c);
            if (alu_out !== r || {N, Z, V, C} !== {n, z, v, c}) begin
                errors++; $display("[TB] FAIL rand_alu cycle %0d got %h %b expected %h %b", k, alu_out, {N, Z, V, C}, r, {n, z, v, c});
            end
            checks++;
            if (rf_B !== rf_m[rf_readB]) begin
                errors++; $display("[TB] FAIL rand_rfb cycle %0d got %h expected %h", k, rf_B, rf_m[rf_readB]);
            end
            checks++;
            tick();
            if (pc_addr !== pc_m || mem_dataout !== mdo_m || OutR !== outr_m) begin
                errors++; $display("[TB] FAIL rand_regs cycle %0d got pc %h mdo %h outr %h expected %h %h %h", k, pc_addr, mem_dataout, OutR, pc_m, mdo_m, outr_m);
            end
            checks++;
        end
        idle();
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_memory();
        test_back_to_back();
        test_mem_fill();
        test_regs();
        test_flags();
        test_pc();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 clk  in  1  single system clock, all state rising-edge; no parameters, all widths fixed.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 mem_wen  in  1  data-memory write enable.
REQ-004 mem_ren  in  1  data-memory read enable.
REQ-005 mem_addr  in  8  data-memory word address (256 x 16).
REQ-006 mem_datain  in  16  data-memory write data.
REQ-007 mem_dataout  out  16  registered data-memory read data.
REQ-008 pc_en  in  1  PC update enable.
REQ-009 pc_inc0_jum1  in  1  PC mode: 0 = increment, 1 = load pc_ext.
REQ-010 pc_ext  in  16  PC jump target.
REQ-011 pc_addr  out  16  current PC value.
REQ-012 rf_en  in  1  register-file write enable.
REQ-013 rf_addr  in  3  register-file write address.
REQ-014 rf_op  in  2  write-data select: 0 alu_out, 1 mem_dataout, 2 pc_addr, 3 ext_immB.
REQ-015 rf_readA  in  3  read port A address (ALU operand A, OutR source).
REQ-016 rf_readB  in  3  read port B address.
REQ-017 rf_B  out  16  combinational contents of R[rf_readB].
REQ-018 add0_sub1  in  1  ALU op: 0 = A+B, 1 = A-B.
REQ-019 LHI  in  1  load-high-immediate select.
REQ-020 LLI  in  1  load-low-immediate select.
REQ-021 ext_imm  in  1  operand-B select: 1 = ext_immB, 0 = rf_B.
REQ-022 ext_immB  in  16  immediate operand.
REQ-023 alu_out  out  16  combinational ALU result.
REQ-024 N, Z, V, C  out  1 each  combinational flags of alu_out.
REQ-025 ctro_outR  in  1  output-register load enable.
REQ-026 OutR  out  16  registered output port.

Function
REQ-027 Memory: 256x16 array; write at clk edge when mem_wen (mem_datain -> M[mem_addr]); when mem_ren, mem_dataout <= M[mem_addr], else it holds; same-edge write+read of one address returns old data.
REQ-028 PC: when pc_en, pc_addr <= pc_inc0_jum1 ? pc_ext : pc_addr+1, mod 2^16 (0xFFFF+1 = 0x0000); holds otherwise.
REQ-029 Register file: 8x16; A = R[rf_readA], rf_B = R[rf_readB], combinational, no write bypass (reads of the register being written return old value until the edge).
REQ-030 When rf_en, R[rf_addr] <= value chosen by rf_op at the edge; R0 is an ordinary writable register.
REQ-031 ALU operand B = ext_imm ? ext_immB : rf_B.
REQ-032 Priority: LHI -> alu_out = {B[7:0], A[7:0]}; else LLI -> alu_out = {A[15:8], B[7:0]}; else add0_sub1 selects A+B or A+~B+1, truncated to 16 bits.
REQ-033 N = alu_out[15]; Z = (alu_out == 0).
REQ-034 Add/sub: C = carry-out of the 17-bit sum (sub: 1 = no borrow); V = signed two's-complement overflow; LHI/LLI force C = V = 0.
REQ-035 OutR: when ctro_outR, OutR <= R[rf_readA] at the edge; holds otherwise.
REQ-036 Same-edge enables are independent; all may fire together, each reading pre-edge values.

Reset
REQ-037 rst asserted: immediately clear pc_addr, mem_dataout, OutR, R0-R7 to 0x0000 regardless of clk; memory array not cleared; all writes suppressed while rst is high.

Verification
REQ-038 mem_wen, addr 0x00, data 0x5487, then mem_ren at addr 0x00 -> mem_dataout = 0x5487 one edge later.
REQ-039 After reset, LLI, ext_imm, ext_immB=0x00FF, readA=0, rf_op=0, write R0 then R1 -> R0 = R1 = 0x00FF.
REQ-040 LLI 0x12 into R2, LLI 0x34 into R3, then readA=2, readB=3, ext_imm=0, add -> alu_out 0x0046, N=Z=V=C=0; write R4.
REQ-041 ctro_outR with readA = 0..4 on successive edges -> OutR = 0x00FF, 0x00FF, 0x0012, 0x0034, 0x0046.
REQ-042 Sub 0x0034-0x0034 -> Z=1, C=1; add 0x7FFF+0x0001 -> 0x8000, N=1, V=1; LHI B=0x00AB with A=0x00CD -> 0xABCD.
REQ-043 PC increment from 0xFFFF -> 0x0000; jump to pc_ext 0x1234; rst asserted mid-clock-high clears pc_addr and OutR immediately.
